// File: rtl/osnt_sume_cutter_arbiter.sv
// Packet-granular round-robin arbiter feeding the packet cutter from NUM_PORTS RX streams.
// Whole packets only; software can quiesce it at a packet boundary with pause_req.
module osnt_sume_cutter_arbiter #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS          = 4
) (
  input  logic                                        axi_aclk,
  input  logic                                        axi_resetn,

  input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic [NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
  input  logic [NUM_PORTS-1:0]                        s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]                        s_axis_tlast,
  output logic [NUM_PORTS-1:0]                        s_axis_tready,

  output logic [C_AXIS_DATA_WIDTH-1:0]                m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]              m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]               m_axis_tuser,
  output logic                                        m_axis_tvalid,
  output logic                                        m_axis_tlast,
  input  logic                                        m_axis_tready,

  input  logic                                        pause_req,
  output logic                                        paused,

  input  logic                                        clr_cnt,
  output logic [NUM_PORTS*32-1:0]                     pkt_cnt
);

  localparam int KEEP_WIDTH = C_AXIS_DATA_WIDTH / 8;
  localparam int GW         = $clog2(NUM_PORTS);

  typedef enum logic {
    IDLE,
    PASS
  } state_t;

  state_t                         state_q;
  state_t                         state_d;
  logic [GW-1:0]                  grant_q;
  logic [GW-1:0]                  grant_d;
  logic [GW-1:0]                  last_grant_q;
  logic [GW-1:0]                  last_grant_d;

  logic [GW-1:0]                  rr_pick;
  logic                           rr_found;
  logic [GW-1:0]                  rr_cand;
  int                             rr_idx;

  logic                           out_ready;
  logic                           beat_acc;
  logic                           pkt_done;

  logic [C_AXIS_DATA_WIDTH-1:0]   sel_tdata;
  logic [KEEP_WIDTH-1:0]          sel_tkeep;
  logic [C_AXIS_TUSER_WIDTH-1:0]  sel_tuser;
  logic                           sel_tlast;

  logic [NUM_PORTS*32-1:0]        pkt_cnt_q;
  logic                           paused_q;

  // Round-robin search: walking candidates from farthest to nearest leaves the
  // nearest requester after last_grant as the final winner.
  always_comb begin
    rr_pick  = last_grant_q;
    rr_found = 1'b0;
    rr_idx   = 0;
    rr_cand  = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      rr_idx  = (int'(last_grant_q) + k) % NUM_PORTS;
      rr_cand = GW'(rr_idx);
      if (s_axis_tvalid[rr_cand]) begin
        rr_pick  = rr_cand;
        rr_found = 1'b1;
      end
    end
  end

  assign sel_tdata = s_axis_tdata[grant_q*C_AXIS_DATA_WIDTH +: C_AXIS_DATA_WIDTH];
  assign sel_tkeep = s_axis_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH];
  assign sel_tuser = s_axis_tuser[grant_q*C_AXIS_TUSER_WIDTH +: C_AXIS_TUSER_WIDTH];
  assign sel_tlast = s_axis_tlast[grant_q];

  assign out_ready = ~m_axis_tvalid | m_axis_tready;
  assign beat_acc  = s_axis_tvalid[grant_q] & s_axis_tready[grant_q];
  assign pkt_done  = beat_acc & sel_tlast;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_PORTS - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  // pause_req is only looked at between packets, so a granted packet always completes.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (!pause_req && rr_found) begin
          grant_d = rr_pick;
          state_d = PASS;
        end
      end
      PASS: begin
        if (pkt_done) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    if (state_q == PASS) begin
      s_axis_tready[grant_q] = out_ready;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
    end else if (beat_acc) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= sel_tlast;
      m_axis_tdata  <= sel_tdata;
      m_axis_tkeep  <= sel_tkeep;
      m_axis_tuser  <= sel_tuser;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // A clear in the same cycle as a completed packet takes priority over the increment.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      pkt_cnt_q <= '0;
    end else if (clr_cnt) begin
      pkt_cnt_q <= '0;
    end else if (pkt_done) begin
      pkt_cnt_q[grant_q*32 +: 32] <= pkt_cnt_q[grant_q*32 +: 32] + 32'd1;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      paused_q <= 1'b0;
    end else begin
      paused_q <= (state_q == IDLE) && !m_axis_tvalid && pause_req;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
  assign paused  = paused_q;

endmodule

// File: tb/tb_osnt_sume_cutter_arbiter.sv
// Self-checking bench for osnt_sume_cutter_arbiter: randomized sources and sink against a
// packet-level reference model, plus directed fairness, backpressure, pause, counter and reset steps.
module tb_osnt_sume_cutter_arbiter;

  localparam int N  = 4;
  localparam int DW = 256;
  localparam int KW = DW / 8;
  localparam int UW = 128;

  logic            axi_aclk = 1'b0;
  logic            axi_resetn;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N*KW-1:0] s_axis_tkeep;
  logic [N*UW-1:0] s_axis_tuser;
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    s_axis_tlast;
  logic [N-1:0]    s_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic [KW-1:0]   m_axis_tkeep;
  logic [UW-1:0]   m_axis_tuser;
  logic            m_axis_tvalid;
  logic            m_axis_tlast;
  logic            m_axis_tready;
  logic            pause_req;
  logic            paused;
  logic            clr_cnt;
  logic [N*32-1:0] pkt_cnt;

  always #5 axi_aclk = ~axi_aclk;

  osnt_sume_cutter_arbiter #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(UW),
    .NUM_PORTS         (N)
  ) dut (
    .axi_aclk     (axi_aclk),
    .axi_resetn   (axi_resetn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .pause_req    (pause_req),
    .paused       (paused),
    .clr_cnt      (clr_cnt),
    .pkt_cnt      (pkt_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Source side: each port holds at most one packet of up to 4 beats.
  logic [DW-1:0] src_data [N][4];
  logic [KW-1:0] src_keep [N][4];
  logic [UW-1:0] src_user [N][4];
  int            src_len   [N];
  int            src_idx   [N];
  int            pkts_left [N];
  int            fixed_len [N];
  bit            have_pkt  [N];
  bit            showing   [N];
  bit            delay_en;
  bit            clr_on_last;
  int            tready_mode;
  int            cyc;

  // Reference model of what the arbiter should present.
  bit            mdl_busy;
  int            mdl_cur;
  int            mdl_last;
  bit            mdl_out_valid;
  bit            mdl_paused;
  logic [DW-1:0] mdl_data;
  logic [KW-1:0] mdl_keep;
  logic [UW-1:0] mdl_user;
  logic          mdl_tlast;
  logic [31:0]   mdl_cnt [N];
  logic [N*32-1:0] force_val;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    mdl_busy      = 1'b0;
    mdl_cur       = 0;
    mdl_last      = N - 1;
    mdl_out_valid = 1'b0;
    mdl_paused    = 1'b0;
    mdl_data      = '0;
    mdl_keep      = '0;
    mdl_user      = '0;
    mdl_tlast     = 1'b0;
    for (int p = 0; p < N; p++) mdl_cnt[p] = '0;
  endtask

  task automatic gen_packet(input int p);
    src_len[p] = (fixed_len[p] > 0) ? fixed_len[p] : int'($urandom_range(1, 4));
    for (int i = 0; i < src_len[p]; i++) begin
      for (int w = 0; w < DW / 32; w++) src_data[p][i][w*32 +: 32] = $urandom;
      for (int w = 0; w < UW / 32; w++) src_user[p][i][w*32 +: 32] = $urandom;
      src_keep[p][i] = $urandom;
    end
    src_idx[p]  = 0;
    have_pkt[p] = 1'b1;
  endtask

  task automatic abandon_sources();
    for (int p = 0; p < N; p++) begin
      have_pkt[p]  = 1'b0;
      showing[p]   = 1'b0;
      pkts_left[p] = 0;
      fixed_len[p] = 0;
    end
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
  endtask

  // Drives one cycle of inputs; called just after the active edge.
  task automatic applyStimulus();
    for (int p = 0; p < N; p++) begin
      if (!have_pkt[p] && pkts_left[p] > 0) gen_packet(p);
      if (have_pkt[p] && !showing[p] && (!delay_en || $urandom_range(3) != 0)) showing[p] = 1'b1;
      s_axis_tvalid[p] = showing[p];
      s_axis_tlast[p]  = have_pkt[p] && (src_idx[p] == src_len[p] - 1);
      if (have_pkt[p]) begin
        s_axis_tdata[p*DW +: DW] = src_data[p][src_idx[p]];
        s_axis_tkeep[p*KW +: KW] = src_keep[p][src_idx[p]];
        s_axis_tuser[p*UW +: UW] = src_user[p][src_idx[p]];
      end
    end
    case (tready_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: m_axis_tready = ($urandom_range(3) != 0);
    endcase
    if (clr_on_last) begin
      clr_cnt = mdl_busy && showing[mdl_cur] && (!mdl_out_valid || m_axis_tready) &&
                (src_idx[mdl_cur] == src_len[mdl_cur] - 1);
    end
    cyc++;
  endtask

  // Compares DUT outputs with the model, then advances the model across the coming edge.
  task automatic sample_and_check();
    logic [N-1:0]    exp_tready;
    logic [N*32-1:0] exp_cnt;
    int              acc;
    bit              was_busy;
    bit              nxt_paused;
    bit              inc;
    exp_tready = '0;
    for (int p = 0; p < N; p++) begin
      if (mdl_busy && p == mdl_cur) exp_tready[p] = !mdl_out_valid || m_axis_tready;
      exp_cnt[p*32 +: 32] = mdl_cnt[p];
    end
    checkOutput("s_tready", s_axis_tready, exp_tready);
    checkOutput("m_tvalid", m_axis_tvalid, mdl_out_valid);
    checkOutput("m_tlast", m_axis_tlast, mdl_tlast);
    checkOutput("m_tdata", m_axis_tdata, mdl_data);
    checkOutput("m_tkeep", m_axis_tkeep, mdl_keep);
    checkOutput("m_tuser", m_axis_tuser, mdl_user);
    checkOutput("paused", paused, mdl_paused);
    checkOutput("pkt_cnt", pkt_cnt, exp_cnt);

    was_busy   = mdl_busy;
    nxt_paused = !mdl_busy && !mdl_out_valid && pause_req;
    inc        = 1'b0;
    acc        = -1;
    if (mdl_busy && s_axis_tvalid[mdl_cur] && exp_tready[mdl_cur]) acc = mdl_cur;
    if (acc >= 0) begin
      mdl_data      = src_data[acc][src_idx[acc]];
      mdl_keep      = src_keep[acc][src_idx[acc]];
      mdl_user      = src_user[acc][src_idx[acc]];
      mdl_tlast     = (src_idx[acc] == src_len[acc] - 1);
      mdl_out_valid = 1'b1;
      showing[acc]  = 1'b0;
      if (mdl_tlast) begin
        have_pkt[acc] = 1'b0;
        pkts_left[acc]--;
        mdl_busy = 1'b0;
        mdl_last = acc;
        inc      = 1'b1;
      end else begin
        src_idx[acc]++;
      end
    end else if (mdl_out_valid && m_axis_tready) begin
      mdl_out_valid = 1'b0;
    end
    if (!was_busy && !pause_req && (s_axis_tvalid != '0)) begin
      for (int k = 1; k <= N; k++) begin
        if (s_axis_tvalid[(mdl_last + k) % N]) begin
          mdl_cur  = (mdl_last + k) % N;
          mdl_busy = 1'b1;
          break;
        end
      end
    end
    if (clr_cnt) begin
      for (int p = 0; p < N; p++) mdl_cnt[p] = '0;
    end else if (inc) begin
      mdl_cnt[acc] = mdl_cnt[acc] + 32'd1;
    end
    mdl_paused = nxt_paused;
  endtask

  task automatic cycle();
    applyStimulus();
    @(negedge axi_aclk);
    sample_and_check();
    @(posedge axi_aclk);
    #1;
  endtask

  function automatic bit drained();
    bit d;
    d = !mdl_busy && !mdl_out_valid;
    for (int p = 0; p < N; p++) if (pkts_left[p] > 0 || have_pkt[p]) d = 1'b0;
    return d;
  endfunction

  task automatic run_until_idle(input int limit);
    int n;
    n = 0;
    while (!drained() && n < limit) begin
      cycle();
      n++;
    end
  endtask

  task automatic set_port(input int p, input int npkts, input int len);
    pkts_left[p] = npkts;
    fixed_len[p] = len;
  endtask

  initial begin
    axi_resetn    = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b0;
    pause_req     = 1'b0;
    clr_cnt       = 1'b0;
    delay_en      = 1'b0;
    clr_on_last   = 1'b0;
    tready_mode   = 0;
    cyc           = 0;
    abandon_sources();
    mdl_reset();

    repeat (2) @(posedge axi_aclk);
    #1;
    checkOutput("rst_m_tvalid", m_axis_tvalid, 1'b0);
    checkOutput("rst_m_tlast", m_axis_tlast, 1'b0);
    checkOutput("rst_m_tdata", m_axis_tdata, '0);
    checkOutput("rst_m_tkeep", m_axis_tkeep, '0);
    checkOutput("rst_m_tuser", m_axis_tuser, '0);
    checkOutput("rst_s_tready", s_axis_tready, '0);
    checkOutput("rst_paused", paused, 1'b0);
    checkOutput("rst_pkt_cnt", pkt_cnt, '0);
    axi_resetn = 1'b1;

    $display("[TB] single 3-beat packet on port 0");
    set_port(0, 1, 3);
    run_until_idle(50);
    checkOutput("single_cnt0", pkt_cnt[31:0], 32'd1);

    $display("[TB] fairness with all ports sending 2-beat packets");
    clr_cnt = 1'b1;
    cycle();
    clr_cnt = 1'b0;
    for (int p = 0; p < N; p++) set_port(p, 2, 2);
    run_until_idle(200);
    for (int p = 0; p < N; p++) checkOutput($sformatf("fair_cnt%0d", p), pkt_cnt[p*32 +: 32], 32'd2);

    $display("[TB] backpressure on a 4-beat packet");
    tready_mode = 1;
    cyc = 0;
    set_port(2, 1, 4);
    run_until_idle(100);
    tready_mode = 0;

    $display("[TB] pause during a port 1 packet while port 2 waits");
    set_port(1, 1, 4);
    set_port(2, 1, 2);
    for (int n = 0; n < 20 && !(mdl_busy && mdl_cur == 1 && src_idx[1] == 1); n++) cycle();
    pause_req = 1'b1;
    repeat (8) cycle();
    checkOutput("pause_paused", paused, 1'b1);
    checkOutput("pause_no_grant", s_axis_tready, '0);
    checkOutput("pause_port2_cnt", pkt_cnt[95:64], mdl_cnt[2]);
    pause_req = 1'b0;
    run_until_idle(50);

    $display("[TB] counter wrap and clear-versus-increment");
    for (int p = 0; p < N; p++) force_val[p*32 +: 32] = mdl_cnt[p];
    force_val[127:96] = 32'hFFFF_FFFF;
    force dut.pkt_cnt_q = force_val;
    #1;
    release dut.pkt_cnt_q;
    mdl_cnt[3] = 32'hFFFF_FFFF;
    set_port(3, 1, 1);
    run_until_idle(50);
    checkOutput("wrap_cnt3", pkt_cnt[127:96], 32'd0);
    clr_on_last = 1'b1;
    set_port(0, 1, 2);
    run_until_idle(50);
    clr_on_last = 1'b0;
    clr_cnt = 1'b0;
    checkOutput("clr_wins", pkt_cnt, '0);

    $display("[TB] randomized traffic with backpressure, pause and clears");
    delay_en    = 1'b1;
    tready_mode = 2;
    for (int p = 0; p < N; p++) set_port(p, int'($urandom_range(3, 8)), 0);
    for (int n = 0; n < 3000 && !drained(); n++) begin
      if ($urandom_range(19) == 0) pause_req = !pause_req;
      clr_cnt = ($urandom_range(63) == 0);
      cycle();
    end
    pause_req = 1'b0;
    clr_cnt   = 1'b0;
    run_until_idle(300);
    delay_en    = 1'b0;
    tready_mode = 0;

    $display("[TB] reset asserted in the middle of a packet");
    set_port(3, 1, 4);
    for (int n = 0; n < 20 && !(mdl_busy && mdl_cur == 3 && src_idx[3] == 2); n++) cycle();
    axi_resetn = 1'b0;
    #1;
    checkOutput("midrst_m_tvalid", m_axis_tvalid, 1'b0);
    checkOutput("midrst_s_tready", s_axis_tready, '0);
    abandon_sources();
    mdl_reset();
    @(posedge axi_aclk);
    #1;
    axi_resetn = 1'b1;
    set_port(1, 1, 2);
    set_port(3, 1, 2);
    cycle();
    applyStimulus();
    @(negedge axi_aclk);
    checkOutput("first_grant_after_reset", s_axis_tready, 4'b0010);
    sample_and_check();
    @(posedge axi_aclk);
    #1;
    run_until_idle(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
